// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - sequencer and Floyd attractor detector driving the GNR node array
//
// Optional feature macro: GNR_PERIOD_EN (attractor period measurement).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, init_vec     host request (sampled in IDLE) and initial state captured with it
//   busy, done          run in progress / one-cycle result-valid pulse
//   timeout             no attractor found before the step or period counter saturated
//   steps, period       fast-trajectory steps at detection / attractor period (0 without feature)
//   attr_state          s0 vector captured at detection
//   reset_nos           node strobe: load init_state
//   start_s0, start_s1  node strobes: advance slow / fast copy
//   init_state          per-node init bits from the captured init_vec
//   s0_vec, s1_vec      returned slow / fast node state vectors
module gnr_attractor_ctrl #(
  parameter int N_NODES = 188,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   steps,
  output logic [CNT_W-1:0]   period,
  output logic [N_NODES-1:0] attr_state,
  output logic               reset_nos,
  output logic               start_s0,
  output logic               start_s1,
  output logic [N_NODES-1:0] init_state,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    CHECK,
    FIN
`ifdef GNR_PERIOD_EN
    , P_STEP,
    P_CHECK
`endif
  } state_t;

  state_t state, state_d;
  logic   capture;
  logic   latch_attr;
  logic   set_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    capture     = 1'b0;
    latch_attr  = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD:  state_d = STEP;
      STEP:  state_d = CHECK;
      CHECK: begin
        // Odd step counts are skipped: right after load both copies sit at f^1.
        if (!steps[0] && (s0_vec == s1_vec)) begin
          latch_attr = 1'b1;
`ifdef GNR_PERIOD_EN
          state_d    = P_STEP;
`else
          state_d    = FIN;
`endif
        end else if (steps == CNT_MAX) begin
          set_timeout = 1'b1;
          state_d     = FIN;
        end else begin
          state_d = STEP;
        end
      end
`ifdef GNR_PERIOD_EN
      P_STEP: state_d = P_CHECK;
      P_CHECK: begin
        if (s1_vec == attr_state) begin
          state_d = FIN;
        end else if (period == CNT_MAX) begin
          set_timeout = 1'b1;
          state_d     = FIN;
        end else begin
          state_d = P_STEP;
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and status are registered from the next state so they line up
  // exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      steps      <= '0;
      attr_state <= '0;
      init_state <= '0;
      reset_nos  <= 1'b0;
      start_s0   <= 1'b0;
      start_s1   <= 1'b0;
    end else begin
      reset_nos <= (state_d == LOAD);
      start_s0  <= (state_d == STEP);
`ifdef GNR_PERIOD_EN
      start_s1  <= (state_d == STEP) || (state_d == P_STEP);
`else
      start_s1  <= (state_d == STEP);
`endif
      done      <= (state_d == FIN);

      if (capture) begin
        busy       <= 1'b1;
        timeout    <= 1'b0;
        steps      <= '0;
        attr_state <= '0;
        init_state <= init_vec;
      end else begin
        if (state_d == FIN) begin
          busy <= 1'b0;
        end
        if (set_timeout) begin
          timeout <= 1'b1;
        end
        // STEP is only re-entered below CNT_MAX, so steps cannot wrap.
        if (state_d == STEP) begin
          steps <= steps + 1'b1;
        end
        if (latch_attr) begin
          attr_state <= s0_vec;
        end
      end
    end
  end

`ifdef GNR_PERIOD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= '0;
    end else if (capture) begin
      period <= '0;
    end else if (state_d == P_STEP) begin
      period <= period + 1'b1;
    end
  end
`else
  assign period = '0;
`endif

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - directed self-checking bench for gnr_attractor_ctrl
module tb_gnr_attractor_ctrl;

  localparam int N = 3;
  localparam int W = 8;
`ifdef GNR_PERIOD_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] init_vec = '0;
  logic         busy, done, timeout;
  logic [W-1:0] steps, period;
  logic [N-1:0] attr_state, init_state, s0_vec, s1_vec;
  logic         reset_nos, start_s0, start_s1;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int ovl_cnt = 0;

  logic [1:0]   net_sel = 2'd0;
  logic         frc = 1'b0;
  logic [N-1:0] m_s0, m_s1;
  logic         m_par;

  gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_vec(init_vec),
    .busy(busy), .done(done), .timeout(timeout), .steps(steps),
    .period(period), .attr_state(attr_state), .reset_nos(reset_nos),
    .start_s0(start_s0), .start_s1(start_s1), .init_state(init_state),
    .s0_vec(s0_vec), .s1_vec(s1_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] nf(input logic [1:0] net, input logic [N-1:0] x);
    case (net)
      2'd1:    nf = {x[1:0], x[2]};
      2'd2: begin
        case (x)
          3'b000:  nf = 3'b001;
          3'b001:  nf = 3'b010;
          3'b010:  nf = 3'b011;
          3'b011:  nf = 3'b010;
          default: nf = 3'b000;
        endcase
      end
      default: nf = x;
    endcase
  endfunction

  // Node array model: slow copy advances on every other start_s0 pulse.
  always @(posedge clk) begin
    if (reset_nos) begin
      m_s0  <= init_state;
      m_s1  <= init_state;
      m_par <= 1'b0;
    end else begin
      if (start_s1) m_s1 <= nf(net_sel, m_s1);
      if (start_s0) begin
        if (!m_par) m_s0 <= nf(net_sel, m_s0);
        m_par <= ~m_par;
      end
    end
  end

  assign s0_vec = m_s0;
  assign s1_vec = frc ? ~m_s0 : m_s1;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  always @(negedge clk) begin
    if (reset_nos && (start_s0 || start_s1)) ovl_cnt <= ovl_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_case(input string tag, input logic [1:0] net, input logic [N-1:0] init,
                          input logic force_ne, input int rep_at, input int e_steps,
                          input int e_period, input int e_attr, input int e_to);
    int lat;
    int d0;
    logic seen;
    int e_lat;
    e_lat = 3 + 2 * e_steps + 2 * e_period;
    net_sel = net;
    frc = force_ne;
    d0 = done_cnt;
    seen = 1'b0;
    @(negedge clk);
    init_vec = init;
    start = 1'b1;
    lat = 1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 2) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (lat == rep_at) begin
        start = 1'b1;
        init_vec = 3'b100;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(e_lat));
    check({tag, "_steps"}, 32'(steps), 32'(e_steps));
    check({tag, "_period"}, 32'(period), 32'(e_period));
    check({tag, "_attr"}, 32'(attr_state), 32'(e_attr));
    check({tag, "_timeout"}, 32'(timeout), 32'(e_to));
    check({tag, "_busy_fin"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_hold_steps"}, 32'(steps), 32'(e_steps));
    frc = 1'b0;
  endtask

  initial begin
    int d0;
    logic hit;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_steps", 32'(steps), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_strobes", 32'({reset_nos, start_s0, start_s1}), 32'd0);
    check("rst_init_state", 32'(init_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_case("ident", 2'd0, 3'b101, 1'b0, 0, 2, PEN * 1, 5, 0);
    run_case("rotl",  2'd1, 3'b001, 1'b0, 0, 6, PEN * 3, 1, 0);
    run_case("tail",  2'd2, 3'b000, 1'b0, 0, 4, PEN * 2, 2, 0);
    run_case("tmo",   2'd0, 3'b011, 1'b1, 0, 255, 0, 0, 1);
    run_case("repls", 2'd1, 3'b001, 1'b0, 3, 6, PEN * 3, 1, 0);

    // Reset in the middle of a run.
    d0 = done_cnt;
    net_sel = 2'd0;
    @(negedge clk);
    init_vec = 3'b110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start_s0) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_reach_step", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_strobes", 32'({reset_nos, start_s0, start_s1}), 32'd0);
    check("mid_steps", 32'(steps), 32'd0);
    check("mid_init_state", 32'(init_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_idle_busy", 32'(busy), 32'd0);

    run_case("fresh", 2'd0, 3'b101, 1'b0, 0, 2, PEN * 1, 5, 0);

    check("strobe_overlap", 32'(ovl_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
